// File: rtl/slice_packer.sv
// Slice packer: collects W-bit slices into an N*W frame, slice k at [k*W +: W].
// Supports partial-frame flush and holds the frame until the consumer accepts it.
module slice_packer #(
   parameter  int W  = 10,
   parameter  int N  = 48,
   localparam int CW = $clog2(N+1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   in_data,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           flush,
   output logic [N*W-1:0] out_data,
   output logic [CW-1:0]  out_count,
   output logic           out_valid,
   input  logic           out_ready
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {FILL, HOLD} state_t;

   state_t              state_q;
   logic [IW-1:0]       idx_q;
   logic [CW-1:0]       cnt_q;
   logic [N-1:0][W-1:0] lane_q;

   logic acc, last, close, drain;

   assign acc   = (state_q == FILL) && in_valid;
   assign last  = (idx_q == IW'(N-1));
   assign close = (acc && (last || flush)) ||
                  ((state_q == FILL) && !acc && flush && (idx_q != '0));
   assign drain = (state_q == HOLD) && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            FILL: begin
               if (acc) begin
                  cnt_q <= CW'(idx_q) + CW'(1);
                  idx_q <= close ? '0 : idx_q + IW'(1);
               end else if (close) begin
                  idx_q <= '0;
               end
               if (close) state_q <= HOLD;
            end
            HOLD: begin
               if (drain) begin
                  state_q <= FILL;
                  cnt_q   <= '0;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   // One register per slice; the frame clears as a whole on the output handshake.
   for (genvar g = 0; g < N; g++) begin : g_lane
      always_ff @(posedge clk or posedge rst) begin
         if (rst)                              lane_q[g] <= '0;
         else if (drain)                       lane_q[g] <= '0;
         else if (acc && (idx_q == IW'(g)))    lane_q[g] <= in_data;
      end
   end

   // in_ready is masked by rst so the producer sees no ready while reset is held.
   assign in_ready  = (state_q == FILL) && !rst;
   assign out_valid = (state_q == HOLD);
   assign out_data  = lane_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_slice_packer.sv
// Directed table vectors, hand-written corner sequences and a randomized scoreboard for slice_packer.
module tb_slice_packer;
   localparam int W  = 10;
   localparam int N  = 48;
   localparam int CW = $clog2(N+1);

   logic           clk = 1'b0;
   logic           rst;
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_ready;
   logic           flush;
   logic [N*W-1:0] out_data;
   logic [CW-1:0]  out_count;
   logic           out_valid;
   logic           out_ready;

   slice_packer #(.W(W), .N(N)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .out_data(out_data), .out_count(out_count), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         n;
      bit         fl_last;
      logic [9:0] val;
      int         exp_cnt;
   } vec_t;

   vec_t vt[6];
   int total = 0, passed = 0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] v);
      in_valid = 1'b1;
      in_data  = v;
      tick();
      in_valid = 1'b0;
   endtask

   function automatic logic [N*W-1:0] fill_vec(input int n, input logic [W-1:0] v);
      logic [N*W-1:0] e;
      e = '0;
      for (int i = 0; i < n; i++) e[i*W +: W] = v;
      return e;
   endfunction

   logic [N*W-1:0] exp_v;
   logic [W-1:0]   q[$];
   bit             mh;
   int             frames, cyc;

   initial begin
      vt[0] = '{n: 5,  fl_last: 1'b0, val: 10'h3FF, exp_cnt: 5};
      vt[1] = '{n: 5,  fl_last: 1'b1, val: 10'h3FF, exp_cnt: 5};
      vt[2] = '{n: 1,  fl_last: 1'b1, val: 10'h155, exp_cnt: 1};
      vt[3] = '{n: 1,  fl_last: 1'b0, val: 10'h2AA, exp_cnt: 1};
      vt[4] = '{n: 47, fl_last: 1'b0, val: 10'h0F0, exp_cnt: 47};
      vt[5] = '{n: 48, fl_last: 1'b1, val: 10'h001, exp_cnt: 48};

      rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_data",  out_data, 0);
      chk("rst_count", out_count, 0);
      chk("rst_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("rel_ready", in_ready, 1);

      // flush with nothing written is ignored
      flush = 1'b1; tick(); flush = 1'b0;
      chk("flush0_valid", out_valid, 0);
      chk("flush0_ready", in_ready, 1);

      // full frame, consumer always ready
      out_ready = 1'b1;
      exp_v = '0;
      for (int k = 0; k < N; k++) begin
         exp_v[k*W +: W] = W'(k+1);
         if (k == N-1) chk("full_not_early", out_valid, 0);
         send(W'(k+1));
      end
      chk("full_valid", out_valid, 1);
      chk("full_data",  out_data, exp_v);
      chk("full_count", out_count, N);
      chk("full_ready", in_ready, 0);
      tick();
      chk("full_drain_valid", out_valid, 0);
      chk("full_drain_ready", in_ready, 1);
      chk("full_drain_data",  out_data, 0);
      chk("full_drain_count", out_count, 0);

      // backpressure
      out_ready = 1'b0;
      exp_v = '0;
      for (int k = 0; k < N; k++) begin
         exp_v[k*W +: W] = W'((k*37 + 5) % 1024);
         send(W'((k*37 + 5) % 1024));
      end
      for (int c = 0; c < 20; c++) begin
         in_valid = c[0];
         in_data  = W'($urandom_range(0, 1023));
         tick();
         chk("bp_valid", out_valid, 1);
         chk("bp_data",  out_data, exp_v);
         chk("bp_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("bp_drain_valid", out_valid, 0);
      chk("bp_drain_data",  out_data, 0);
      chk("bp_drain_ready", in_ready, 1);

      // table of partial / flush frames
      for (int t = 0; t < 6; t++) begin
         for (int s = 0; s < vt[t].n; s++) begin
            in_valid = 1'b1;
            in_data  = vt[t].val;
            flush    = (s == vt[t].n - 1) && vt[t].fl_last;
            tick();
         end
         in_valid = 1'b0; flush = 1'b0;
         if (!vt[t].fl_last) begin
            chk($sformatf("tbl%0d_preflush", t), out_valid, 0);
            flush = 1'b1; tick(); flush = 1'b0;
         end
         chk($sformatf("tbl%0d_valid", t), out_valid, 1);
         chk($sformatf("tbl%0d_count", t), out_count, vt[t].exp_cnt);
         chk($sformatf("tbl%0d_data", t),  out_data, fill_vec(vt[t].exp_cnt, vt[t].val));
         flush = 1'b1; tick(); flush = 1'b0;
         chk($sformatf("tbl%0d_holdflush", t), out_count, vt[t].exp_cnt);
         out_ready = 1'b1; tick(); out_ready = 1'b0;
         chk($sformatf("tbl%0d_drain", t), out_valid, 0);
      end

      // flush at idx 0 after a completed frame, then next slice lands at slice 0
      flush = 1'b1; tick(); flush = 1'b0;
      chk("flush0b_valid", out_valid, 0);
      send(10'h123);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("slice0_count", out_count, 1);
      chk("slice0_data",  out_data, fill_vec(1, 10'h123));
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // asynchronous reset mid-frame
      for (int k = 0; k < 30; k++) send(10'h3FF);
      chk("pre_arst_count", out_count, 30);
      #2 rst = 1'b1;
      #1;
      chk("arst_count", out_count, 0);
      chk("arst_data",  out_data, 0);
      chk("arst_ready", in_ready, 0);
      @(posedge clk); @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_rel_ready", in_ready, 1);
      exp_v = '0;
      for (int k = 0; k < N; k++) begin
         exp_v[k*W +: W] = W'(10'h100 + k);
         send(W'(10'h100 + k));
      end
      chk("arst_frame_valid", out_valid, 1);
      chk("arst_frame_data",  out_data, exp_v);
      chk("arst_frame_count", out_count, N);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // randomized traffic against a scoreboard
      mh = 1'b0; frames = 0; cyc = 0;
      q.delete();
      while (frames < 1000 && cyc < 80000) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = W'($urandom_range(0, 1023));
         flush     = ($urandom_range(0, 7) == 0);
         out_ready = 1'($urandom_range(0, 1));
         chk("rnd_ready", in_ready, !mh);
         chk("rnd_valid", out_valid, mh);
         if (mh) begin
            if (out_ready) begin
               exp_v = '0;
               foreach (q[i]) exp_v[i*W +: W] = q[i];
               chk("rnd_data",  out_data, exp_v);
               chk("rnd_count", out_count, q.size());
               q.delete();
               mh = 1'b0;
               frames++;
            end
         end else if (in_valid) begin
            q.push_back(in_data);
            if (q.size() == N || flush) mh = 1'b1;
         end else if (flush && q.size() > 0) begin
            mh = 1'b1;
         end
         tick();
         cyc++;
      end
      if (frames < 1000) chk("rnd_timeout", frames, 1000);
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/slice_packer.md
Name: slice_packer

Overview:
Assembles a wide packed vector from a stream of narrow slices, one slice per valid/ready handshake.
Slice k is written to out_data[k*W +: W], so the result feeds directly into slice-indexed reduction logic that consumes a packed N*W bus.
It supports a partial-frame flush and holds the frame until the consumer accepts it.
Sits between a narrow producer and the wide combinational reducers of the datapath.

Parameters:
W, 10, slice width in bits
N, 48, slices per frame; out_data width is N*W (480 by default)
CW, $clog2(N+1), width of out_count (derived, not overridable)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
in_data  input  W  slice value
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts a slice this cycle
flush  input  1  close the current partial frame
out_data  output  N*W  packed frame; slice k at [k*W +: W]
out_count  output  CW  number of slices written in the presented frame (1..N)
out_valid  output  1  frame is presented
out_ready  input  1  consumer accepts the frame

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to FILL; idx=0.
  - Outputs: out_data=0, out_count=0, out_valid=0, in_ready=0 while rst is asserted, 1 in the first cycle after release.
  - Reset mid-frame discards all slices; no partial frame is emitted.
- Internal state: idx, width $clog2(N), the next slice position.
- FILL state:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid & in_ready: out_data[idx*W +: W] <= in_data; idx <= idx+1; out_count <= idx+1.
  - Accept with idx==N-1: go to HOLD next cycle; idx wraps to 0.
  - flush=1 with idx>0 (or an accept in the same cycle): go to HOLD. Unwritten slices remain 0. out_count = slices written, including a slice accepted in that same cycle.
  - flush=1 with idx==0 and no accept: ignored; no empty frame is ever emitted.
  - flush and an accept at idx==N-1 in the same cycle: one full frame, out_count=N.
- HOLD state:
  - out_valid=1, in_ready=0.
  - out_data and out_count are stable until the handshake; flush is ignored.
  - When out_valid & out_ready: next cycle state=FILL, idx=0, out_data=0, out_count=0, out_valid=0.
- Latency: the last slice (or flush) in cycle t gives out_valid=1 in cycle t+1.
- Throughput: one slice per cycle in FILL. Minimum gap is one cycle, because in_ready=0 in HOLD and in the cycle of the out handshake. A full frame takes at least N+1 cycles.
- in_valid and in_data must not be interpreted while in_ready=0; values presented then are dropped with no state change.
- All arithmetic is unsigned. idx never exceeds N-1. out_count never exceeds N.
- The design is fully synchronous apart from rst and has no combinational path from inputs to outputs. in_ready and out_valid are decoded from state only.

Test Plan:
- Reset then 48 slices with in_data=k+1 (k=0..47), out_ready=1: out_valid rises exactly 1 cycle after the 48th accept; out_data[k*10+:10]=k+1 for all k; out_count=48; in_ready=0 for 1 cycle, then 1 with out_data=0.
- Backpressure: full frame with out_ready=0 for 20 cycles: out_valid and out_data stay stable, in_ready=0; in_valid pulses during the hold are ignored; a single-cycle out_ready completes the handshake.
- Partial flush: 5 slices 0x3FF, then flush alone: out_count=5, out_data[49:0]=all ones, out_data[479:50]=0. Flush on the same cycle as the 5th accept gives the same result.
- Flush with idx==0 (after reset and after a completed frame): out_valid stays 0 and the next slice lands at slice 0.
- Asynchronous rst asserted mid-cycle after 30 slices: outputs clear immediately without a clock edge; after release, 48 new slices produce a frame containing no stale data.
- Random in_valid/out_ready (50% duty cycle), 1000 frames with random flush: a scoreboard matches every frame's slices and out_count; no slice is lost or duplicated.
